// File: rtl/async_fifo.sv
// Single-clock FIFO with binary wrap-bit pointers, registered read data and
// one-cycle overflow/underflow pulses for rejected accesses.
module async_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [PTR_WIDTH:0]    wptr_r;
    logic [PTR_WIDTH:0]    rptr_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_ok_s;
    logic                  rd_ok_s;

    // Status flags and access acceptance, judged on the pre-edge pointers.
    always_comb begin
        empty_s = (wptr_r == rptr_r);
        full_s  = (wptr_r[PTR_WIDTH] != rptr_r[PTR_WIDTH]) &&
                  (wptr_r[PTR_WIDTH-1:0] == rptr_r[PTR_WIDTH-1:0]);
        wr_ok_s = wr_en_i && !full_s;
        rd_ok_s = rd_en_i && !empty_s;
    end

    // Storage array; never reset, and a reset edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_ok_s) begin
            mem_r[wptr_r[PTR_WIDTH-1:0]] <= wdata_i;
        end
    end

    // Pointers, registered read data and error pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_r      <= '0;
            rptr_r      <= '0;
            rdata_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wptr_r <= wptr_r + (PTR_WIDTH+1)'(1);
            end
            if (rd_ok_s) begin
                rptr_r  <= rptr_r + (PTR_WIDTH+1)'(1);
                rdata_r <= mem_r[rptr_r[PTR_WIDTH-1:0]];
            end
            overflow_r  <= wr_en_i && full_s;
            underflow_r <= rd_en_i && empty_s;
        end
    end

    assign rdata_o     = rdata_r;
    assign full_o      = full_s;
    assign empty_o     = empty_s;
    assign overflow_o  = overflow_r;
    assign underflow_o = underflow_r;

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: a hand-computed vector table, directed
// fill/drain corner sequences and random traffic against a queue model.
module tb_async_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 12;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic          rd_en_i = 1'b0;
    logic [DW-1:0] wdata_i = '0;
    logic [DW-1:0] rdata_o;
    logic          full_o;
    logic          empty_o;
    logic          overflow_o;
    logic          underflow_o;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] m_rdata = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    async_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .rd_en_i(rd_en_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .full_o(full_o), .empty_o(empty_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          rst;
        logic          wr;
        logic          rd;
        logic [DW-1:0] data;
        logic [DW-1:0] e_rdata;
        logic          e_full;
        logic          e_empty;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock edge: drive, advance the model, then compare DUT with model
    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        logic pre_full, pre_empty;
        rst_i = r; wr_en_i = w; rd_en_i = rd; wdata_i = d;
        @(posedge clk_i);
        pre_full  = (model_q.size() == DEPTH);
        pre_empty = (model_q.size() == 0);
        if (r) begin
            model_q.delete();
            m_rdata = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (rd && !pre_empty) m_rdata = model_q.pop_front();
            if (w && !pre_full) model_q.push_back(d);
            m_ovf = w && pre_full;
            m_unf = rd && pre_empty;
        end
        #1;
        check("model", {16'h0, rdata_o, full_o, empty_o, overflow_o, underflow_o},
              {16'h0, m_rdata, model_q.size() == DEPTH, model_q.size() == 0, m_ovf, m_unf});
    endtask

    initial begin
        logic [DW-1:0] words[5];

        // rst wr rd data | rdata full empty ovf unf
        vecs[0] = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 12'h5A3, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h5A3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h5A3, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h5A3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 12'h123, 12'h5A3, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 12'h456, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 12'h789, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 12'hABC, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].data);
            check($sformatf("vec%0d", i), {16'h0, rdata_o, full_o, empty_o, overflow_o, underflow_o},
                  {16'h0, vecs[i].e_rdata, vecs[i].e_full, vecs[i].e_empty, vecs[i].e_ovf, vecs[i].e_unf});
        end

        // five random words out in write order
        for (int i = 0; i < 5; i++) begin
            words[i] = DW'($urandom);
            step(1'b0, 1'b1, 1'b0, words[i]);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 12'h000);
            check("order5", {20'h0, rdata_o}, {20'h0, words[i]});
        end
        check("empty_after5", {31'h0, empty_o}, 32'd1);

        // fill to DEPTH, then one more write is dropped with a single overflow pulse
        for (int i = 0; i < DEPTH; i++) begin
            check("full_before", {31'h0, full_o}, 32'd0);
            step(1'b0, 1'b1, 1'b0, DW'(12'h100 + i));
            check("no_ovf_fill", {31'h0, overflow_o}, 32'd0);
        end
        check("full_at16", {31'h0, full_o}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 12'hFFF);
        check("ovf_pulse", {31'h0, overflow_o}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 12'h000);
        check("ovf_clear", {31'h0, overflow_o}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, 12'h000);
            check("drain", {20'h0, rdata_o}, {20'h0, DW'(12'h100 + i)});
        end
        step(1'b0, 1'b0, 1'b1, 12'h000);
        check("unf_pulse", {31'h0, underflow_o}, 32'd1);
        check("rdata_hold", {20'h0, rdata_o}, {20'h0, 12'h10F});
        step(1'b0, 1'b0, 1'b1, 12'h000);
        check("unf_continuous", {31'h0, underflow_o}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 12'h000);
        check("unf_clear", {31'h0, underflow_o}, 32'd0);

        // simultaneous read+write while full: read wins, write overflows
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, DW'(12'h200 + i));
        step(1'b0, 1'b1, 1'b1, 12'hEEE);
        check("rw_full_ovf", {31'h0, overflow_o}, 32'd1);
        check("rw_full_notfull", {31'h0, full_o}, 32'd0);
        check("rw_full_rdata", {20'h0, rdata_o}, {20'h0, 12'h200});
        step(1'b1, 1'b0, 1'b0, 12'h000);

        // random traffic with occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 59) == 0);
            step(r, 1'($urandom), 1'($urandom), DW'($urandom));
            if (r) begin
                check("rst_midstream", {16'h0, rdata_o, full_o, empty_o, overflow_o, underflow_o},
                      {16'h0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
